imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer sitting between the byte-addressed instruction memory and the decode stage.
- Generates word-aligned fetch addresses (PC += 4).
- Holds each memory request until it is acknowledged.
- Buffers fetched words in a small prefetch FIFO.
- Delivers instructions with their PC to decode under a valid/ready handshake.
- Handles branch/jump redirects, including a redirect that arrives while a request is outstanding.

Parameters:
- PCL, 32, address/PC width in bits.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 0, first fetch address after reset.
- NOP, 32'h00000000, value driven on inst while the FIFO is empty.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request to the instruction memory.
- mem_addr  out  PCL  byte address of the requested word.
- mem_ack  in  1  memory has returned data for mem_addr; may be asserted in the same cycle as mem_req.
- mem_rdata  in  32  fetched word, valid when mem_ack=1.
- redirect  in  1  pipeline redirect (branch/jump taken).
- redirect_pc  in  PCL  new fetch address.
- inst_ready  in  1  decode accepts the head entry.
- inst_valid  out  1  head entry is present.
- inst  out  32  head instruction; NOP when empty.
- inst_pc  out  PCL  PC of the head instruction; 0 when empty.
- error  out  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (rst=0), applied immediately without waiting for a clock edge:
  - state=IDLE, fetch_pc=RESET_PC, FIFO count=0.
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=NOP, inst_pc=0, error=0.
- States:
  - IDLE: lasts exactly one cycle after reset release, then goes to REQ.
  - REQ:
    - mem_req = (count<DEPTH) at the start of the cycle; mem_addr=fetch_pc, held stable until mem_ack.
    - On mem_req & mem_ack & !redirect: push {mem_rdata, fetch_pc} and set fetch_pc=fetch_pc+4, modulo 2^PCL, so 0xFFFFFFFC wraps to 0.
    - Consequence: with mem_ack tied high, one instruction is fetched per cycle.
  - KILL:
    - Entered when redirect=1 while mem_req=1 and mem_ack=0.
    - mem_req stays 1 and mem_addr keeps the old address until mem_ack.
    - The acked data is discarded; the next state is REQ with fetch_pc = the latched redirect target.
    - A further redirect while in KILL overwrites the latched target.
  - HALT:
    - Entered on any accepted redirect with redirect_pc[1:0]!=0; error=1.
    - mem_req=0, FIFO flushed, inst_valid=0.
    - Left only by reset.
- Redirect, when redirect_pc[1:0]==0:
  - At the clock edge, the FIFO is flushed (count=0).
  - In REQ with mem_ack=1 or mem_req=0: fetch_pc=redirect_pc; any same-cycle mem_ack data is discarded.
  - In REQ with mem_req=1 and mem_ack=0: the target is latched and the state moves to KILL.
  - inst_valid is 0 in the cycle after the redirect.
  - A pop in the same cycle as a redirect is ignored, since the entry is flushed anyway.
- FIFO:
  - inst_valid = (count!=0); inst and inst_pc come from the head entry.
  - Pop on inst_valid & inst_ready.
  - Simultaneous push and pop is allowed, and count is unchanged.
  - Full: count==DEPTH makes mem_req=0 in that cycle and no push occurs; requests resume the cycle after a pop.
  - Empty: inst=NOP, inst_pc=0.
  - Entries leave in strict fetch order.
  - Pointers wrap modulo DEPTH; count is ($clog2(DEPTH)+1) bits wide.

Optional Feature:
FETCH_STATS_EN
- Defined: adds two 32-bit output ports.
  - stat_fetched: increments on every pushed word.
  - stat_flushed: adds the count of flushed entries on each redirect, plus 1 for each discarded KILL or same-cycle ack.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, mem_ack=1, inst_ready=1 -> mem_addr 0,4,8,12 on consecutive cycles starting the cycle after IDLE; inst_pc sequence 0,4,8,12, one per cycle; error=0.
2. inst_ready=0, mem_ack=1 -> FIFO holds PCs 0,4,8,12 and mem_req=0 once count=4; then inst_ready=1 -> 0,4,8,12,16 in order, no word lost or duplicated.
3. Three entries buffered, redirect=1 with redirect_pc=0x40 -> next cycle inst_valid=0 and inst=NOP; next mem_addr=0x40; first delivered inst_pc=0x40.
4. mem_ack delayed 3 cycles on address 8, redirect to 0x80 in the first wait cycle -> mem_addr stays 8 until ack, that data is never delivered, next mem_addr=0x80.
5. redirect_pc=0x42 -> error=1, mem_req=0 and inst_valid=0 indefinitely; after a reset pulse, error=0 and fetch restarts at RESET_PC.
6. rst driven low mid-KILL, between clock edges -> mem_req=0, inst_valid=0, error=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch controller bus: memory request/ack, pipeline redirect and the decode-side valid/ready port.
// The master modport is the fetch controller; the slave modport is the memory/decode environment.
interface imem_fetch_ctrl_if #(
  parameter int PCL = 32
);
  logic           mem_req;
  logic [PCL-1:0] mem_addr;
  logic           mem_ack;
  logic [31:0]    mem_rdata;
  logic           redirect;
  logic [PCL-1:0] redirect_pc;
  logic           inst_ready;
  logic           inst_valid;
  logic [31:0]    inst;
  logic [PCL-1:0] inst_pc;
  logic           error;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc, error,
    input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc, error,
    output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: one word per cycle with ack tied high, request held until ack, stalls on a full prefetch FIFO.
// Optional FETCH_STATS_EN adds stat_fetched/stat_flushed counters.
module imem_fetch_ctrl #(
  parameter int             PCL      = 32,
  parameter int             DEPTH    = 4,
  parameter logic [PCL-1:0] RESET_PC = '0,
  parameter logic [31:0]    NOP      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_ctrl_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushed
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, KILL, HALT} state_t;

  state_t         state, state_nxt;
  logic [PCL-1:0] fetch_pc, fetch_pc_nxt;
  logic [PCL-1:0] kill_pc, kill_pc_nxt;
  logic           error_q, err_set;
  logic [CW-1:0]  count;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [31:0]    fifo_dat [DEPTH];
  logic [PCL-1:0] fifo_pc  [DEPTH];
  logic           req, push, pop, flush, discard;
  logic           fifo_full, fifo_vld, redir_ok, redir_bad;

  assign fifo_full = (count == CW'(DEPTH));
  assign fifo_vld  = (count != '0);
  assign redir_ok  = bus.redirect & (bus.redirect_pc[1:0] == 2'b00);
  assign redir_bad = bus.redirect & (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    kill_pc_nxt  = kill_pc;
    req          = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    discard      = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redir_bad) begin
          state_nxt = HALT;
          err_set   = 1'b1;
          flush     = 1'b1;
        end else if (redir_ok) begin
          fetch_pc_nxt = bus.redirect_pc;
          flush        = 1'b1;
        end
      end
      REQ: begin
        req = !fifo_full;
        if (redir_bad) begin
          state_nxt = HALT;
          err_set   = 1'b1;
          flush     = 1'b1;
          discard   = req & bus.mem_ack;
        end else if (redir_ok) begin
          flush = 1'b1;
          // An unacked request cannot be withdrawn: park the target until the memory answers.
          if (req && !bus.mem_ack) begin
            state_nxt   = KILL;
            kill_pc_nxt = bus.redirect_pc;
          end else begin
            fetch_pc_nxt = bus.redirect_pc;
            discard      = req & bus.mem_ack;
          end
        end else begin
          pop = fifo_vld & bus.inst_ready;
          if (req && bus.mem_ack) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + PCL'(4);
          end
        end
      end
      KILL: begin
        req = 1'b1;
        if (redir_bad) begin
          state_nxt = HALT;
          err_set   = 1'b1;
          flush     = 1'b1;
          discard   = bus.mem_ack;
        end else begin
          if (redir_ok) begin
            kill_pc_nxt = bus.redirect_pc;
            flush       = 1'b1;
          end
          if (bus.mem_ack) begin
            state_nxt    = REQ;
            discard      = 1'b1;
            fetch_pc_nxt = redir_ok ? bus.redirect_pc : kill_pc;
          end
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      kill_pc  <= RESET_PC;
      error_q  <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      kill_pc  <= kill_pc_nxt;
      if (err_set) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wr_ptr] <= bus.mem_rdata;
      fifo_pc[wr_ptr]  <= fetch_pc;
    end
  end

  assign bus.mem_req    = req;
  assign bus.mem_addr   = fetch_pc;
  assign bus.inst_valid = fifo_vld;
  assign bus.inst       = fifo_vld ? fifo_dat[rd_ptr] : NOP;
  assign bus.inst_pc    = fifo_vld ? fifo_pc[rd_ptr] : '0;
  assign bus.error      = error_q;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (push) stat_fetched <= stat_fetched + 32'd1;
      stat_flushed <= stat_flushed + (flush ? 32'(count) : 32'd0) + 32'(discard);
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; expected deliveries are queued by stimulus and checked by a negedge monitor.
module tb_imem_fetch_ctrl;
  localparam int          PCL = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;

  imem_fetch_ctrl_if #(.PCL(PCL)) bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif

  imem_fetch_ctrl #(.PCL(PCL), .DEPTH(4), .RESET_PC('0), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_flushed (stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: each word is its address scrambled with a fixed key.
  assign bus.mem_rdata = bus.mem_addr ^ KEY;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d deliveries outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_delivery: got pc %0h, expected none", bus.inst_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        check("deliver_pc", {32'h0, bus.inst_pc}, {32'h0, mon_pc});
        check("deliver_inst", {32'h0, bus.inst}, {32'h0, mon_pc ^ KEY});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst             = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    #2;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_inst", bus.inst, NOP);
    check("rst_inst_pc", bus.inst_pc, 0);
    check("rst_error", bus.error, 0);
    tick();
    rst = 1'b1;

    // 1: streaming fetch, one instruction per cycle
    bus.mem_ack = 1'b1;
    bus.inst_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    tick();
    check("t1_idle_req", bus.mem_req, 1);
    check("t1_addr0", bus.mem_addr, 32'h0);
    tick();
    check("t1_addr4", bus.mem_addr, 32'h4);
    check("t1_pc0", bus.inst_pc, 32'h0);
    tick();
    check("t1_addr8", bus.mem_addr, 32'h8);
    check("t1_pc4", bus.inst_pc, 32'h4);
    tick();
    check("t1_addr12", bus.mem_addr, 32'hC);
    check("t1_pc8", bus.inst_pc, 32'h8);
    tick();
    check("t1_pc12", bus.inst_pc, 32'hC);
    check("t1_error", bus.error, 0);
    bus.mem_ack = 1'b0;
    tick();
    bus.inst_ready = 1'b0;
    wait_drain("t1");

    // 2: fill FIFO with decode stalled, then drain in order
    do_reset();
    bus.mem_ack = 1'b1;
    repeat (5) tick();
    check("t2_full_req", bus.mem_req, 0);
    check("t2_full_head", bus.inst_pc, 32'h0);
    tick(); tick();
    check("t2_hold_req", bus.mem_req, 0);
    check("t2_hold_addr", bus.mem_addr, 32'h10);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    bus.inst_ready = 1'b1;
    tick();
    check("t2_resume_req", bus.mem_req, 1);
    check("t2_head4", bus.inst_pc, 32'h4);
    repeat (4) tick();
    bus.inst_ready = 1'b0;
    wait_drain("t2");

    // 3: redirect with three entries buffered and ack high
    do_reset();
    bus.mem_ack = 1'b1;
    repeat (4) tick();
    check("t3_buf_valid", bus.inst_valid, 1);
    check("t3_buf_addr", bus.mem_addr, 32'hC);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    check("t3_flush_valid", bus.inst_valid, 0);
    check("t3_flush_inst", bus.inst, NOP);
    check("t3_flush_pc", bus.inst_pc, 0);
    check("t3_new_addr", bus.mem_addr, 32'h40);
    exp_q.push_back(32'h40);
    bus.inst_ready = 1'b1;
    tick();
    check("t3_head", bus.inst_pc, 32'h40);
    check("t3_next_addr", bus.mem_addr, 32'h44);
    tick();
    bus.inst_ready = 1'b0;
    wait_drain("t3");

    // 4: redirect while the request for address 8 waits for ack
    do_reset();
    bus.mem_ack = 1'b1;
    bus.inst_ready = 1'b1;
    exp_q.push_back(32'h0);
    repeat (3) tick();
    check("t4_wait_addr", bus.mem_addr, 32'h8);
    bus.mem_ack = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h80;
    tick();
    bus.redirect = 1'b0;
    check("t4_kill_req", bus.mem_req, 1);
    check("t4_kill_addr", bus.mem_addr, 32'h8);
    check("t4_kill_valid", bus.inst_valid, 0);
    tick();
    check("t4_kill_addr2", bus.mem_addr, 32'h8);
    tick();
    check("t4_kill_addr3", bus.mem_addr, 32'h8);
    bus.mem_ack = 1'b1;
    tick();
    check("t4_target_addr", bus.mem_addr, 32'h80);
    check("t4_discard_valid", bus.inst_valid, 0);
    exp_q.push_back(32'h80);
    bus.inst_ready = 1'b1;
    tick(); tick();
    bus.inst_ready = 1'b0;
    bus.mem_ack = 1'b0;
    wait_drain("t4");

    // 5: misaligned redirect halts until reset
    do_reset();
    bus.mem_ack = 1'b1;
    repeat (3) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h42;
    tick();
    bus.redirect = 1'b0;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_error", bus.error, 1);
      check("t5_halt_req", bus.mem_req, 0);
      check("t5_halt_valid", bus.inst_valid, 0);
      tick();
    end
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    bus.inst_ready = 1'b0;
    #1;
    check("t5_rst_error", bus.error, 0);
    check("t5_rst_addr", bus.mem_addr, 0);
    tick();
    rst = 1'b1;
    bus.mem_ack = 1'b1;
    bus.inst_ready = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    check("t5_restart_req", bus.mem_req, 1);
    check("t5_restart_addr", bus.mem_addr, 32'h0);
    tick(); tick();
    bus.inst_ready = 1'b0;
    wait_drain("t5");

    // 6: asynchronous reset in the middle of KILL
    do_reset();
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    check("t6_kill_req", bus.mem_req, 1);
    check("t6_kill_addr", bus.mem_addr, 32'h4);
    check("t6_kill_valid", bus.inst_valid, 0);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_req", bus.mem_req, 0);
    check("t6_async_valid", bus.inst_valid, 0);
    check("t6_async_error", bus.error, 0);
    check("t6_async_addr", bus.mem_addr, 0);
    tick();
    rst = 1'b1;
    bus.mem_ack = 1'b1;
    bus.inst_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    check("t6_restart_addr", bus.mem_addr, 32'h0);
    repeat (3) tick();
    bus.inst_ready = 1'b0;
    bus.mem_ack = 1'b0;
    wait_drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
